// File: rtl/gpr_wb.sv
// Write-back queue in front of the gpr write port: arbitrates ALU/load results into
// an in-order FIFO, drains one entry per cycle, and forwards queued data to readers.
module gpr_wb #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_wa,
  input  logic [31:0] alu_wd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_wa,
  input  logic [31:0] ld_wd,
  input  logic        wb_hold,
  output logic        gpr_we,
  output logic [4:0]  gpr_wa,
  output logic [31:0] gpr_wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [4:0]    wa_q [DEPTH];
  logic [31:0]   wd_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fwd1_hit_q, fwd1_hit_d, fwd2_hit_q, fwd2_hit_d;
  logic [31:0]   fwd1_data_q, fwd1_data_d, fwd2_data_q, fwd2_data_d;

  logic          full, sel_ld, push_hs, push, pop;
  logic [4:0]    push_wa;
  logic [31:0]   push_wd;
  logic [AW-1:0] idx;

  // Load wins arbitration; nothing is accepted while in reset
  assign full      = (count_q == CW'(DEPTH));
  assign ld_ready  = !rst && !full;
  assign alu_ready = !rst && !full && !ld_valid;
  assign sel_ld    = ld_valid && ld_ready;
  assign push_hs   = sel_ld || (alu_valid && alu_ready);
  assign push_wa   = sel_ld ? ld_wa : alu_wa;
  assign push_wd   = sel_ld ? ld_wd : alu_wd;
  assign push      = push_hs && (push_wa != 5'd0);

  assign busy   = (count_q != '0);
  assign gpr_we = busy && !wb_hold;
  assign gpr_wa = busy ? wa_q[rptr_q] : 5'd0;
  assign gpr_wd = busy ? wd_q[rptr_q] : 32'd0;
  assign pop    = gpr_we;

  assign fwd1_hit  = fwd1_hit_q;
  assign fwd2_hit  = fwd2_hit_q;
  assign fwd1_data = fwd1_data_q;
  assign fwd2_data = fwd2_data_q;

  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Walk oldest to newest so the newest matching entry overrides older ones
  always_comb begin
    fwd1_hit_d  = 1'b0;
    fwd2_hit_d  = 1'b0;
    fwd1_data_d = 32'd0;
    fwd2_data_d = 32'd0;
    idx         = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rptr_q + AW'(k);
      if (CW'(k) < count_q) begin
        if (ra1 != 5'd0 && wa_q[idx] == ra1) begin
          fwd1_hit_d  = 1'b1;
          fwd1_data_d = wd_q[idx];
        end
        if (ra2 != 5'd0 && wa_q[idx] == ra2) begin
          fwd2_hit_d  = 1'b1;
          fwd2_data_d = wd_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      fwd1_hit_q  <= 1'b0;
      fwd2_hit_q  <= 1'b0;
      fwd1_data_q <= 32'd0;
      fwd2_data_q <= 32'd0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        wa_q[i] <= 5'd0;
        wd_q[i] <= 32'd0;
      end
    end else begin
      if (push) begin
        wa_q[wptr_q] <= push_wa;
        wd_q[wptr_q] <= push_wd;
      end
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      fwd1_hit_q  <= fwd1_hit_d;
      fwd2_hit_q  <= fwd2_hit_d;
      fwd1_data_q <= fwd1_data_d;
      fwd2_data_q <= fwd2_data_d;
    end
  end

endmodule
